// File: rtl/spdif_pair_fifo_if.sv
// spdif_pair_fifo_if: bundles the sample input side and the frame output
// handshake of spdif_pair_fifo.
//   master : source/consumer side (drives data_i, ack_i, lrck_i, locked_i, ready_i)
//   slave  : the pairing FIFO (drives data_l_o, data_r_o, valid_o, level_o,
//            orphan_o, overflow_o)
interface spdif_pair_fifo_if #(
    parameter int FIFO_DEPTH_LOG2 = 3
);
    logic [23:0]              data_i;
    logic                     ack_i;
    logic                     lrck_i;
    logic                     locked_i;
    logic [23:0]              data_l_o;
    logic [23:0]              data_r_o;
    logic                     valid_o;
    logic                     ready_i;
    logic [FIFO_DEPTH_LOG2:0] level_o;
    logic                     orphan_o;
    logic                     overflow_o;

    modport master (
        output data_i, ack_i, lrck_i, locked_i, ready_i,
        input  data_l_o, data_r_o, valid_o, level_o, orphan_o, overflow_o
    );

    modport slave (
        input  data_i, ack_i, lrck_i, locked_i, ready_i,
        output data_l_o, data_r_o, valid_o, level_o, orphan_o, overflow_o
    );
endinterface

// File: rtl/spdif_pair_fifo.sv
// spdif_pair_fifo: pairs each left subframe from the S/PDIF receiver with the
// following right subframe and buffers complete stereo frames in a FIFO of
// 2^FIFO_DEPTH_LOG2 entries, drained by a valid/ready handshake.
// Ports:
//   clk  : system clock (same domain as the receiver)
//   rst  : asynchronous active-high reset
//   bus  : spdif_pair_fifo_if.slave
//          data_i/ack_i/lrck_i/locked_i : per-subframe samples and lock level
//          data_l_o/data_r_o/valid_o/ready_i : head frame handshake
//          level_o    : stored frame count
//          orphan_o   : pulse, a sample was discarded by pairing
//          overflow_o : sticky, a complete frame was dropped on full FIFO
module spdif_pair_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input logic         clk,
    input logic         rst,
    spdif_pair_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

    typedef enum logic {
        EMPTY  = 1'b0,
        HAVE_L = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [23:0] l_hold;
    logic [23:0] l_hold_next;
    logic        push;
    logic        orphan_next;
    logic        orphan_q;
    logic        overflow_q;

    logic [FIFO_DEPTH_LOG2:0] wptr;
    logic [FIFO_DEPTH_LOG2:0] rptr;
    logic [47:0]              mem [DEPTH];
    logic                     empty;
    logic                     full;
    logic                     pop;
    logic                     wr_en;
    logic                     ovf_set;

    // Pairing FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            l_hold   <= '0;
            orphan_q <= 1'b0;
        end else begin
            state    <= state_next;
            l_hold   <= l_hold_next;
            orphan_q <= orphan_next;
        end
    end

    // Pairing FSM: next state. Loss of lock discards a held left sample
    // silently, regardless of any strobe in the same cycle.
    always_comb begin
        state_next  = state;
        l_hold_next = l_hold;
        push        = 1'b0;
        orphan_next = 1'b0;
        if (!bus.locked_i) begin
            state_next = EMPTY;
        end else if (bus.ack_i) begin
            unique case (state)
                EMPTY: begin
                    if (!bus.lrck_i) begin
                        l_hold_next = bus.data_i;
                        state_next  = HAVE_L;
                    end else begin
                        orphan_next = 1'b1;
                    end
                end
                HAVE_L: begin
                    if (!bus.lrck_i) begin
                        l_hold_next = bus.data_i;
                        orphan_next = 1'b1;
                    end else begin
                        push       = 1'b1;
                        state_next = EMPTY;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // FIFO control: extra pointer MSB distinguishes full from empty
    assign empty   = (wptr == rptr);
    assign full    = (wptr[FIFO_DEPTH_LOG2] != rptr[FIFO_DEPTH_LOG2]) &&
                     (wptr[FIFO_DEPTH_LOG2-1:0] == rptr[FIFO_DEPTH_LOG2-1:0]);
    assign pop     = !empty && bus.ready_i;
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Frame storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[FIFO_DEPTH_LOG2-1:0]] <= {l_hold, bus.data_i};
        end
    end

    assign bus.valid_o    = !empty;
    assign bus.data_l_o   = empty ? '0 : mem[rptr[FIFO_DEPTH_LOG2-1:0]][47:24];
    assign bus.data_r_o   = empty ? '0 : mem[rptr[FIFO_DEPTH_LOG2-1:0]][23:0];
    assign bus.level_o    = wptr - rptr;
    assign bus.orphan_o   = orphan_q;
    assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_spdif_pair_fifo.sv
module tb_spdif_pair_fifo;
    localparam int N     = 3;
    localparam int DEPTH = 1 << N;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   orph_seen;

    spdif_pair_fifo_if #(.FIFO_DEPTH_LOG2(N)) bus ();

    spdif_pair_fifo #(.FIFO_DEPTH_LOG2(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of stored frames and an optional pending left sample
    logic [47:0] mq[$];
    logic [23:0] hold[$];
    logic        exp_orph;
    logic        exp_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        hold.delete();
        exp_orph = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    // Monitor/scoreboard, evaluated mid-cycle when DUT outputs and the inputs
    // for the next edge are stable
    always @(negedge clk) begin
        logic        orph;
        logic [47:0] frame;
        if (rst) begin
            model_clear();
        end else begin
            if (bus.orphan_o) orph_seen++;
            check("valid", 64'(bus.valid_o), 64'(mq.size() != 0));
            check("level", 64'(bus.level_o), 64'(mq.size()));
            check("orphan", 64'(bus.orphan_o), 64'(exp_orph));
            check("overflow", 64'(bus.overflow_o), 64'(exp_ovf));
            if (mq.size() == 0) begin
                check("idle_data", {16'h0, bus.data_l_o, bus.data_r_o}, 64'h0);
            end else if (bus.ready_i) begin
                check("pop_l", 64'(bus.data_l_o), 64'(mq[0][47:24]));
                check("pop_r", 64'(bus.data_r_o), 64'(mq[0][23:0]));
                void'(mq.pop_front());
            end
            orph = 1'b0;
            if (!bus.locked_i) begin
                hold.delete();
            end else if (bus.ack_i) begin
                if (!bus.lrck_i) begin
                    if (hold.size() != 0) begin
                        orph = 1'b1;
                        hold.delete();
                    end
                    hold.push_back(bus.data_i);
                end else if (hold.size() != 0) begin
                    frame = {hold[0], bus.data_i};
                    hold.delete();
                    if (mq.size() < DEPTH) mq.push_back(frame);
                    else exp_ovf = 1'b1;
                end else begin
                    orph = 1'b1;
                end
            end
            exp_orph = orph;
        end
    end

    task automatic step(input logic ack, input logic lr, input logic lk,
                        input logic [23:0] d, input logic rdy);
        @(posedge clk);
        #1;
        bus.ack_i    = ack;
        bus.lrck_i   = lr;
        bus.locked_i = lk;
        bus.data_i   = d;
        bus.ready_i  = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 24'h0, rdy);
    endtask

    task automatic pair(input logic [23:0] l, input logic [23:0] r, input logic rdy);
        step(1'b1, 1'b0, 1'b1, l, rdy);
        idle(1, rdy);
        step(1'b1, 1'b1, 1'b1, r, rdy);
        idle(1, rdy);
    endtask

    initial begin
        int base;
        total = 0;
        bad = 0;
        orph_seen = 0;
        model_clear();
        rst = 1'b1;
        bus.ack_i = 1'b0;
        bus.lrck_i = 1'b0;
        bus.locked_i = 1'b1;
        bus.data_i = '0;
        bus.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 64'(bus.valid_o), 64'h0);
        check("rst_level", 64'(bus.level_o), 64'h0);
        check("rst_flags", {62'h0, bus.orphan_o, bus.overflow_o}, 64'h0);

        // Basic pair
        step(1'b1, 1'b0, 1'b1, 24'h123456, 1'b0);
        idle(63, 1'b0);
        step(1'b1, 1'b1, 1'b1, 24'hABCDEF, 1'b0);
        idle(1, 1'b0);
        check("basic_valid", 64'(bus.valid_o), 64'h1);
        check("basic_l", 64'(bus.data_l_o), 64'h123456);
        check("basic_r", 64'(bus.data_r_o), 64'hABCDEF);
        check("basic_level", 64'(bus.level_o), 64'h1);
        idle(1, 1'b1);
        idle(1, 1'b0);
        check("basic_drained", {15'h0, bus.valid_o, bus.data_l_o, bus.data_r_o}, 64'h0);

        // Orphans: R, L, L, R
        base = orph_seen;
        step(1'b1, 1'b1, 1'b1, 24'd1, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 24'd2, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 24'd3, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b1, 1'b1, 24'd4, 1'b0);
        idle(2, 1'b0);
        check("orphan_count", 64'(orph_seen - base), 64'd2);
        check("orphan_level", 64'(bus.level_o), 64'd1);
        check("orphan_frame", {16'h0, bus.data_l_o, bus.data_r_o}, {16'h0, 24'd3, 24'd4});
        idle(3, 1'b1);

        // Overflow: 9 pairs, then push with simultaneous pop while full
        for (int i = 1; i <= 9; i++) pair(24'(i), 24'(256 + i), 1'b0);
        check("ovf_level", 64'(bus.level_o), 64'd8);
        check("ovf_flag", 64'(bus.overflow_o), 64'd1);
        step(1'b1, 1'b0, 1'b1, 24'h0000AA, 1'b0);
        idle(1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 24'h0000BB, 1'b1);
        idle(1, 1'b0);
        check("full_pushpop_level", 64'(bus.level_o), 64'd8);
        idle(12, 1'b1);

        // Unlock with a stored backlog
        pair(24'h111111, 24'h222222, 1'b0);
        pair(24'h333333, 24'h444444, 1'b0);
        base = orph_seen;
        step(1'b1, 1'b0, 1'b1, 24'h555555, 1'b0);
        for (int i = 0; i < 10; i++) step(i == 4, 1'b1, 1'b0, 24'h666666, 1'b0);
        idle(1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 24'h777777, 1'b0);
        idle(2, 1'b0);
        check("unlock_orphans", 64'(orph_seen - base), 64'd1);
        check("unlock_level", 64'(bus.level_o), 64'd2);
        check("unlock_head", {16'h0, bus.data_l_o, bus.data_r_o}, {16'h0, 24'h111111, 24'h222222});
        idle(4, 1'b1);

        // Asynchronous reset with level 5 and a held left sample
        for (int i = 0; i < 5; i++) pair(24'(32 + i), 24'(64 + i), 1'b0);
        step(1'b1, 1'b0, 1'b1, 24'h0F0F0F, 1'b0);
        @(posedge clk);
        #1;
        bus.ack_i = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus.valid_o), 64'h0);
        check("arst_level", 64'(bus.level_o), 64'h0);
        check("arst_data", {16'h0, bus.data_l_o, bus.data_r_o}, 64'h0);
        check("arst_flags", {62'h0, bus.orphan_o, bus.overflow_o}, 64'h0);
        model_clear();
        #1;
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b1, 24'h0A0A0A, 1'b0);
        idle(1, 1'b0);
        pair(24'h010203, 24'h040506, 1'b0);
        check("arst_next_level", 64'(bus.level_o), 64'd1);
        idle(2, 1'b1);

        // Streaming
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b1, 24'($urandom), $urandom_range(0, 3) != 0);
            for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                idle(1, $urandom_range(0, 3) != 0);
            step(1'b1, 1'b1, 1'b1, 24'($urandom), $urandom_range(0, 3) != 0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                idle(1, $urandom_range(0, 3) != 0);
        end
        idle(20, 1'b1);
        check("stream_overflow", 64'(bus.overflow_o), 64'h0);
        check("stream_level", 64'(bus.level_o), 64'h0);
        check("stream_sb_empty", 64'(mq.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
